// File: rtl/ecc_encoder.sv
// -----------------------------------------------------------------------------
// ecc_encoder
//   Write-side ECC generator for the downstream SEC checker. Each 32-bit data
//   word is extended with 6 Hamming check bits and 1 overall (even) parity
//   bit. Words pass through a registered output stage backed by a one-entry
//   skid buffer, so the block sustains one word per clock while keeping
//   in_ready free of any combinational path from out_ready. A one-shot
//   error-injection mask can be armed to corrupt the next accepted word.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   in_valid     upstream word valid
//   in_ready     block can accept a word this cycle (registered)
//   in_data      32-bit data word to encode
//   out_valid    encoded word valid
//   out_ready    downstream accepts the word
//   out_data     data bits, possibly injected
//   out_parity   [5:0] Hamming check bits, [6] overall parity, possibly injected
//   inj_arm      pulse: capture inj_mask and arm injection
//   inj_mask     [31:0] data flip mask, [38:32] check-bit flip mask
//   inj_pending  injection armed but not yet applied to a word
//   word_cnt     words transferred on the output (wrapping)
//   inj_cnt      transferred words that carried an injection (wrapping)
// -----------------------------------------------------------------------------
module ecc_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [6:0]       out_parity,
    input  logic             inj_arm,
    input  logic [38:0]      inj_mask,
    output logic             inj_pending,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] inj_cnt
);

    // Data bit k sits at the k-th non-power-of-two codeword position starting
    // at 3; check bit i covers every position with bit i set. The overall bit
    // makes the full 39-bit codeword even parity.
    function automatic logic [6:0] calc_parity(input logic [31:0] d);
        logic [6:0] c;
        logic [4:0] k;
        logic [5:0] pv;
        c = '0;
        k = '0;
        for (int p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                pv = p[5:0];
                if (d[k]) begin
                    c[5:0] = c[5:0] ^ pv;
                end
                k = k + 5'd1;
            end
        end
        c[6] = (^d) ^ (^c[5:0]);
        return c;
    endfunction

    // Stored words are {parity[6:0], data[31:0]} so the injection mask lines
    // up bit for bit.
    logic             or_vld_q, or_vld_d;
    logic [38:0]      or_word_q, or_word_d;
    logic             or_inj_q, or_inj_d;
    logic             sk_vld_q, sk_vld_d;
    logic [38:0]      sk_word_q, sk_word_d;
    logic             sk_inj_q, sk_inj_d;
    logic             inj_pending_q, inj_pending_d;
    logic [38:0]      mask_q, mask_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d;

    logic             accept;
    logic             drain;
    logic [38:0]      new_word;

    always_comb begin
        or_vld_d      = or_vld_q;
        or_word_d     = or_word_q;
        or_inj_d      = or_inj_q;
        sk_vld_d      = sk_vld_q;
        sk_word_d     = sk_word_q;
        sk_inj_d      = sk_inj_q;
        inj_pending_d = inj_pending_q;
        mask_d        = mask_q;
        word_cnt_d    = word_cnt_q;
        inj_cnt_d     = inj_cnt_q;

        accept   = in_valid && !sk_vld_q;
        drain    = or_vld_q && out_ready;
        new_word = {calc_parity(in_data), in_data} ^ (inj_pending_q ? mask_q : 39'd0);

        if (drain) begin
            if (sk_vld_q) begin
                // Skid entry moves forward; in_ready was low so no accept here.
                or_word_d = sk_word_q;
                or_inj_d  = sk_inj_q;
                sk_vld_d  = 1'b0;
            end else if (accept) begin
                // Drain and refill in the same cycle: no bubble.
                or_word_d = new_word;
                or_inj_d  = inj_pending_q;
            end else begin
                or_vld_d  = 1'b0;
            end
        end else if (accept) begin
            if (!or_vld_q) begin
                or_vld_d  = 1'b1;
                or_word_d = new_word;
                or_inj_d  = inj_pending_q;
            end else begin
                sk_vld_d  = 1'b1;
                sk_word_d = new_word;
                sk_inj_d  = inj_pending_q;
            end
        end

        // An accept consumes the old arm before a coincident arm re-arms, so
        // the word accepted alongside inj_arm stays clean.
        if (accept) begin
            inj_pending_d = 1'b0;
        end
        if (inj_arm) begin
            mask_d        = inj_mask;
            inj_pending_d = 1'b1;
        end

        if (drain) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (or_inj_q) begin
                inj_cnt_d = inj_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_vld_q      <= 1'b0;
            or_word_q     <= '0;
            or_inj_q      <= 1'b0;
            sk_vld_q      <= 1'b0;
            sk_word_q     <= '0;
            sk_inj_q      <= 1'b0;
            inj_pending_q <= 1'b0;
            mask_q        <= '0;
            word_cnt_q    <= '0;
            inj_cnt_q     <= '0;
        end else begin
            or_vld_q      <= or_vld_d;
            or_word_q     <= or_word_d;
            or_inj_q      <= or_inj_d;
            sk_vld_q      <= sk_vld_d;
            sk_word_q     <= sk_word_d;
            sk_inj_q      <= sk_inj_d;
            inj_pending_q <= inj_pending_d;
            mask_q        <= mask_d;
            word_cnt_q    <= word_cnt_d;
            inj_cnt_q     <= inj_cnt_d;
        end
    end

    assign in_ready    = !sk_vld_q;
    assign out_valid   = or_vld_q;
    assign out_data    = or_word_q[31:0];
    assign out_parity  = or_word_q[38:32];
    assign inj_pending = inj_pending_q;
    assign word_cnt    = word_cnt_q;
    assign inj_cnt     = inj_cnt_q;

endmodule
